comp_serial_ctrl: RTL and testbench
===================================

COMP_SERIAL_CTRL -- requirements
Module: comp_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be even and >= 2.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request a comparison; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A, unsigned; sampled on the accepting edge.
REQ-006 Port: b  input  WIDTH  operand B, unsigned; sampled on the accepting edge.
REQ-007 Port: busy  output  1  high while in COMPARE or DONE.
REQ-008 Port: done  output  1  one-cycle pulse when the result is valid.
REQ-009 Port: greater  output  1  registered result, A > B.
REQ-010 Port: lesser  output  1  registered result, A < B.
REQ-011 Port: equal  output  1  registered result, A == B.

Function
REQ-012 The block SHALL compare the operands MSB-first, one 2-bit slice per cycle, using internal 2-bit greater/lesser/equal slice logic.
REQ-013 The FSM SHALL have exactly three states: IDLE, COMPARE, DONE.
REQ-014 IDLE with start=1 SHALL latch a and b into internal registers, set the slice index to WIDTH/2-1, and go to COMPARE.
REQ-015 IDLE with start=0 SHALL stay in IDLE with all outputs held.
REQ-016 Each COMPARE cycle SHALL evaluate slice [2*idx+1 : 2*idx] of the latched operands.
REQ-017 A greater or lesser slice SHALL load the matching result flag (other two flags 0) and go to DONE (early termination).
REQ-018 An equal slice with idx==0 SHALL load equal=1 (greater=lesser=0) and go to DONE.
REQ-019 An equal slice with idx>0 SHALL decrement idx and stay in COMPARE; idx SHALL never wrap below 0.
REQ-020 DONE SHALL assert done=1 for exactly that one cycle and then go to IDLE unconditionally.
REQ-021 The result flags SHALL update only on the edge entering DONE and then hold until the next entry to DONE; exactly one flag SHALL be high after the first completion.
REQ-022 On the accepting edge of a new start, the result flags SHALL be cleared to 0 and stay 0 until the next DONE.
REQ-023 busy SHALL be 0 in IDLE and 1 in COMPARE and DONE; it is decoded from state.
REQ-024 Latency: for an accept at edge 0 and first differing slice k (counted from the MSB, k=1..WIDTH/2), done SHALL be high in cycle k+1. Equal operands SHALL give done in cycle WIDTH/2+1.
REQ-025 start while busy=1 SHALL be ignored, and a/b changes while busy SHALL not affect the result.
REQ-026 start held high SHALL be accepted again in the IDLE cycle after DONE, giving back-to-back operation with one idle cycle between requests.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, idx=0, latched operands=0, and busy=done=greater=lesser=equal=0.
REQ-028 rst asserted mid-COMPARE or in DONE SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 a=0xA5, b=0xA5, start pulse at edge 0 -> busy cycles 1-5, done=1 in cycle 5, equal=1, greater=lesser=0.
REQ-030 a=0xC0, b=0x40 -> top slice 11>01, done=1 in cycle 2, greater=1; flags held after done drops.
REQ-031 a=0x12, b=0x13 -> lowest slice 10<11, done=1 in cycle 5, lesser=1.
REQ-032 Accept a=0x00, b=0x01, then in cycle 2 pulse start with a=0xFF and change b -> second start ignored, done in cycle 5 with lesser=1.
REQ-033 Accept a=0x55, b=0x55, assert rst in cycle 3 -> all outputs 0 asynchronously, no done pulse; new start a=0x80, b=0x7F -> greater=1 in cycle 2 of that run.
REQ-034 start held high, a=0x40, b=0x80 -> done pulses every 3 cycles, lesser=1 each time, flags 0 between each accept and its DONE.

Source files
------------

// File: rtl/comp_serial_ctrl.sv
// rtl/comp_serial_ctrl.sv - serial MSB-first magnitude comparator, one 2-bit slice per cycle
module comp_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             lesser,
    output logic             equal
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;

    logic [1:0]       w_slice_a;
    logic [1:0]       w_slice_b;
    logic             w_slice_gt;
    logic             w_slice_lt;
    logic             w_accept;
    logic             w_finish;

    // Slice under test is selected from the latched operands, so input changes while busy are invisible.
    assign w_slice_a  = r_a[{r_idx, 1'b0} +: 2];
    assign w_slice_b  = r_b[{r_idx, 1'b0} +: 2];
    assign w_slice_gt = (w_slice_a > w_slice_b);
    assign w_slice_lt = (w_slice_a < w_slice_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_slice_gt || w_slice_lt || (r_idx == '0)) begin
                    w_finish     = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_gt  <= 1'b0;
            r_lt  <= 1'b0;
            r_eq  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_idx <= IDX_TOP;
            r_gt  <= 1'b0;
            r_lt  <= 1'b0;
            r_eq  <= 1'b0;
        end else if (r_state == S_COMPARE) begin
            if (w_finish) begin
                r_gt <= w_slice_gt;
                r_lt <= w_slice_lt;
                r_eq <= ~(w_slice_gt | w_slice_lt);
            end else begin
                r_idx <= r_idx - IDX_W'(1);
            end
        end
    end

    assign busy    = (r_state == S_COMPARE) || (r_state == S_DONE);
    assign done    = (r_state == S_DONE);
    assign greater = r_gt;
    assign lesser  = r_lt;
    assign equal   = r_eq;

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// tb/tb_comp_serial_ctrl.sv - randomized self-checking bench for comp_serial_ctrl against a behavioural model
module tb_comp_serial_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         greater;
    logic         lesser;
    logic         equal;

    int n_checks;
    int n_fail;

    comp_serial_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .greater (greater),
        .lesser  (lesser),
        .equal   (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Result from plain magnitude comparison; latency from the highest differing bit position.
    function automatic void model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                  output int lat, output logic [2:0] flags);
        logic [W-1:0] x;
        int p;
        x = va ^ vb;
        p = -1;
        for (int i = 0; i < W; i++) if (x[i]) p = i;
        if (p < 0) lat = W / 2 + 1;
        else       lat = (W / 2 - p / 2) + 1;
        flags = {va > vb, va < vb, va == vb};
    endfunction

    function automatic logic [2:0] outs();
        return {greater, lesser, equal};
    endfunction

    // Called at a falling edge while IDLE; returns at the falling edge of cycle lat+1.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input bit disturb);
        int lat;
        logic [2:0] fl;
        model(va, vb, lat, fl);
        a = va;
        b = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            check("busy", 32'(busy), 32'(c <= lat));
            check("done", 32'(done), 32'(c == lat));
            check("flags", 32'(outs()), (c < lat) ? 32'd0 : 32'(fl));
            if (disturb && c == 1) begin
                start = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
            end else if (disturb && c == 2) begin
                start = 1'b0;
            end
            if (c <= lat) @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("rst_outs", 32'({busy, done, outs()}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", 32'({busy, done, outs()}), 32'd0);

        run_op(8'hA5, 8'hA5, 1'b0);
        run_op(8'hC0, 8'h40, 1'b0);
        repeat (2) @(negedge clk);
        check("hold_gt", 32'(outs()), 32'b100);
        run_op(8'h12, 8'h13, 1'b0);
        run_op(8'h00, 8'h01, 1'b1);

        // Back-to-back with start held: accepts at edges 0,3,6.
        a = 8'h40;
        b = 8'h80;
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("b2b_busy", 32'(busy), 32'((c % 3) != 0));
            check("b2b_done", 32'(done), 32'((c % 3) == 2));
            check("b2b_flags", 32'(outs()), ((c % 3) == 1) ? 32'd0 : 32'b010);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Abort mid-compare; outputs must clear without a clock edge.
        a = 8'h55;
        b = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst", 32'({busy, done, outs()}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst", 32'({busy, done}), 32'd0);
        end
        run_op(8'h80, 8'h7F, 1'b0);

        for (int n = 0; n < 60; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
